// File: rtl/mcdf_pkg.sv
// Shared MCDF types: arbiter FSM states and the pkglen code decoder
// that the arbiter and the slave_fifo channels both use.
package mcdf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN,
    GAP
  } arb_state_e;

  localparam int MAX_PKG = 32;

  function automatic logic [5:0] pkglen_decode(input logic [2:0] code);
    logic [5:0] len;
    unique case (code)
      3'd0:    len = 6'd4;
      3'd1:    len = 6'd8;
      3'd2:    len = 6'd16;
      default: len = 6'(MAX_PKG);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner picker: lowest prio among i_req, ties broken
// round-robin starting at the channel after i_rr_ptr.
// Ports: i_req, i_prio (2b/ch), i_rr_ptr -> o_idx, o_found.
module arb_rr_pick #(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]   i_req,
  input  logic [NUM_CH*2-1:0] i_prio,
  input  logic [2:0]          i_rr_ptr,
  output logic [2:0]          o_idx,
  output logic                o_found
);

  logic [7:0]  w_req;
  logic [15:0] w_prio;
  logic [3:0]  w_k;
  logic [1:0]  w_best;

  always_comb begin
    w_req  = '0;
    w_prio = '0;
    w_req[NUM_CH-1:0]    = i_req;
    w_prio[NUM_CH*2-1:0] = i_prio;
    w_k     = '0;
    w_best  = 2'd3;
    o_idx   = '0;
    o_found = 1'b0;
    // Visit channels in rr order; strict '<' keeps the earliest on ties.
    for (int i = 1; i <= NUM_CH; i++) begin
      w_k = {1'b0, i_rr_ptr} + 4'(i);
      if (w_k >= 4'(NUM_CH))
        w_k = w_k - 4'(NUM_CH);
      if (w_req[w_k[2:0]] &&
          (!o_found || w_prio[{w_k[2:0], 1'b0} +: 2] < w_best)) begin
        o_found = 1'b1;
        o_idx   = w_k[2:0];
        w_best  = w_prio[{w_k[2:0], 1'b0} +: 2];
      end
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants one slave packet at a time, streams it out with
// SOP/EOP/id. Ports: slv_* in, a2s_ack_o, arb_* out. Macro ARB_STAT_EN adds stat_pkt_o.
module mcdf_arbiter
  import mcdf_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DW     = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NUM_CH-1:0]    slv_req_i,
  input  logic [NUM_CH-1:0]    slv_valid_i,
  input  logic [NUM_CH*DW-1:0] slv_data_i,
  input  logic [NUM_CH*2-1:0]  slv_prio_i,
  input  logic [NUM_CH*3-1:0]  slv_pkglen_i,
  input  logic [6:0]           fmt_margin_i,
  output logic [NUM_CH-1:0]    a2s_ack_o,
  output logic                 arb_valid_o,
  output logic [DW-1:0]        arb_data_o,
  output logic [2:0]           arb_id_o,
  output logic                 arb_sop_o,
  output logic                 arb_eop_o,
  output logic                 arb_busy_o
`ifdef ARB_STAT_EN
  ,
  output logic [NUM_CH*16-1:0] stat_pkt_o
`endif
);

  arb_state_e r_state, w_next;

  logic [2:0]        r_gnt_ch, r_rr_ptr, r_id;
  logic [5:0]        r_gnt_len, r_ack_cnt, r_word_cnt;
  logic [NUM_CH-1:0] r_ack, w_ack_d, w_elig;
  logic [5:0]        w_len [NUM_CH];
  logic [5:0]        w_win_len;
  logic [2:0]        w_win, w_gch;
  logic              w_found;
  logic              w_sv, w_cap, w_last;
  logic [DW-1:0]     w_sd, r_data;
  logic              r_valid, r_sop, r_eop;

  always_comb begin
    w_win_len = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_len[k]  = pkglen_decode(slv_pkglen_i[k*3 +: 3]);
      w_elig[k] = slv_req_i[k] &&
                  (fmt_margin_i >= {1'b0, w_len[k]});
      if (w_win == 3'(k))
        w_win_len = w_len[k];
    end
  end

  arb_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .i_req    (w_elig),
    .i_prio   (slv_prio_i),
    .i_rr_ptr (r_rr_ptr),
    .o_idx    (w_win),
    .o_found  (w_found)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_found) w_next = GRANT;
      GRANT: if (r_ack_cnt == r_gnt_len - 6'd1)
               w_next = DRAIN;
      DRAIN: w_next = GAP;
      GAP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ack is registered: decode the ack for the upcoming cycle here.
  always_comb begin
    w_gch   = (r_state == IDLE) ? w_win : r_gnt_ch;
    w_ack_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      w_ack_d[k] = (w_next == GRANT) && (w_gch == 3'(k));
  end

  assign arb_busy_o = (r_state != IDLE);
  assign a2s_ack_o  = r_ack;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_gnt_ch  <= '0;
      r_gnt_len <= '0;
      r_rr_ptr  <= '0;
      r_ack_cnt <= '0;
      r_ack     <= '0;
    end else begin
      r_ack <= w_ack_d;
      if (r_state == IDLE && w_found) begin
        r_gnt_ch  <= w_win;
        r_gnt_len <= w_win_len;
        r_rr_ptr  <= w_win;
        r_ack_cnt <= '0;
      end else if (r_state == GRANT) begin
        r_ack_cnt <= r_ack_cnt + 6'd1;
      end
    end
  end

  always_comb begin
    w_sv = 1'b0;
    w_sd = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_gnt_ch == 3'(k)) begin
        w_sv = slv_valid_i[k];
        w_sd = slv_data_i[k*DW +: DW];
      end
    end
  end

  // Slave words land one cycle after each ack: GRANT (2nd on) and DRAIN.
  assign w_cap  = ((r_state == GRANT) || (r_state == DRAIN)) && w_sv;
  assign w_last = (r_word_cnt == r_gnt_len - 6'd1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_id       <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_valid <= w_cap;
      r_data  <= w_cap ? w_sd : '0;
      r_id    <= w_cap ? r_gnt_ch : 3'd0;
      r_sop   <= w_cap && (r_word_cnt == 6'd0);
      r_eop   <= w_cap && w_last;
      if (w_cap)
        r_word_cnt <= w_last ? 6'd0 : r_word_cnt + 6'd1;
    end
  end

  assign arb_valid_o = r_valid;
  assign arb_data_o  = r_data;
  assign arb_id_o    = r_id;
  assign arb_sop_o   = r_sop;
  assign arb_eop_o   = r_eop;

`ifdef ARB_STAT_EN
  logic [15:0] r_stat [NUM_CH];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NUM_CH; k++)
        r_stat[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (w_cap && w_last && r_gnt_ch == 3'(k))
          r_stat[k] <= r_stat[k] + 16'd1;
    end
  end

  always_comb begin
    stat_pkt_o = '0;
    for (int k = 0; k < NUM_CH; k++)
      stat_pkt_o[k*16 +: 16] = r_stat[k];
  end
`endif

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Self-checking bench for mcdf_arbiter: directed scenarios plus random
// traffic against a packet-level schedule model.
module tb_mcdf_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req, sv, ack;
  logic [N*DW-1:0] sd;
  logic [N*2-1:0]  prio;
  logic [N*3-1:0]  plen;
  logic [6:0]      margin;
  logic            av, asop, aeop, abusy;
  logic [DW-1:0]   ad;
  logic [2:0]      aid;
`ifdef ARB_STAT_EN
  logic [N*16-1:0] stat;
`endif

  mcdf_arbiter #(.NUM_CH(N), .DW(DW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .slv_req_i    (req),
    .slv_valid_i  (sv),
    .slv_data_i   (sd),
    .slv_prio_i   (prio),
    .slv_pkglen_i (plen),
    .fmt_margin_i (margin),
    .a2s_ack_o    (ack),
    .arb_valid_o  (av),
    .arb_data_o   (ad),
    .arb_id_o     (aid),
    .arb_sop_o    (asop),
    .arb_eop_o    (aeop),
    .arb_busy_o   (abusy)
`ifdef ARB_STAT_EN
    ,
    .stat_pkt_o   (stat)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  // Model: current/last packet = channel mch, length ml, first ack cycle ms.
  int ms  = -1000;
  int ml  = 0;
  int mch = 0;
  int mrr = 0;
  int mstat [N];
  int n_ack;
  int gq [$];
  logic [N-1:0] last_ack;
  logic [N-1:0] rq;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fdat(input int c, input int k);
    return (32'(c) * 32'h9E37_79B1) ^ (32'(k) << 28);
  endfunction

  function automatic int lenof(input logic [2:0] code);
    if (code == 3'd0) return 4;
    if (code == 3'd1) return 8;
    if (code == 3'd2) return 16;
    return 32;
  endfunction

  function automatic logic [5:0] pv(input int a, input int b, input int c);
    return {2'(c), 2'(b), 2'(a)};
  endfunction

  function automatic logic [8:0] lv(input int a, input int b, input int c);
    return {3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic check();
    logic [N-1:0]  e_ack;
    logic          vwin;
    logic [DW-1:0] e_dat;
    e_ack = '0;
    if (cyc >= ms && cyc < ms + ml)
      e_ack[mch] = 1'b1;
    vwin  = (cyc >= ms + 2) && (cyc < ms + ml + 2);
    e_dat = vwin ? fdat(cyc - 1, mch) : '0;
    chk("ack",   64'(ack),   64'(e_ack));
    chk("busy",  64'(abusy), 64'(cyc < ms + ml + 2));
    chk("valid", 64'(av),    64'(vwin));
    chk("data",  64'(ad),    64'(e_dat));
    chk("sop",   64'(asop),  64'(vwin && cyc == ms + 2));
    chk("eop",   64'(aeop),  64'(vwin && cyc == ms + ml + 1));
    if (vwin)
      chk("id", 64'(aid), 64'(mch));
    if (vwin && cyc == ms + ml + 1)
      mstat[mch]++;
  endtask

  task automatic decide();
    int best, bp, k;
    if (cyc < ms + ml + 2) return;
    best = -1;
    bp   = 4;
    for (int i = 1; i <= N; i++) begin
      k = (mrr + i) % N;
      if (req[k] && int'(margin) >= lenof(plen[k*3 +: 3]) &&
          int'(prio[k*2 +: 2]) < bp) begin
        best = k;
        bp   = int'(prio[k*2 +: 2]);
      end
    end
    if (best >= 0) begin
      ms  = cyc + 1;
      ml  = lenof(plen[best*3 +: 3]);
      mch = best;
      mrr = best;
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N*2-1:0] p,
                       input logic [N*3-1:0] l, input logic [6:0] m);
    logic [N-1:0] spur;
    @(posedge clk);
    #1;
    cyc++;
    check();
    if (ack != '0) n_ack++;
    if (ack != '0 && last_ack == '0) begin
      for (int k = 0; k < N; k++)
        if (ack[k]) gq.push_back(k);
    end
    // Slave returns a word the cycle after each ack; others may chatter.
    spur = '0;
    for (int k = 0; k < N; k++) begin
      if (k != mch && $urandom_range(0, 3) == 0) spur[k] = 1'b1;
      sd[k*DW +: DW] = fdat(cyc, k);
    end
    sv       = last_ack | spur;
    last_ack = ack;
    req    = r;
    prio   = p;
    plen   = l;
    margin = m;
    decide();
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    req      = '0;
    sv       = '0;
    last_ack = '0;
    #1;
    chk("rst_ack",   64'(ack),   64'd0);
    chk("rst_valid", 64'(av),    64'd0);
    chk("rst_busy",  64'(abusy), 64'd0);
    chk("rst_sop_eop", 64'({asop, aeop, ad}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    ms   = -1000;
    ml   = 0;
    mrr  = 0;
    for (int k = 0; k < N; k++) mstat[k] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req = '0; sv = '0; sd = '0; prio = '0; plen = '0; margin = '0;
    last_ack = '0;
    #3;
    do_reset();

    // Single 4-word packet on ch0.
    n_ack = 0;
    cycle(3'b001, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
    repeat (9) cycle(3'b000, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
    chk("t1_acks", 64'(n_ack), 64'd4);

    // Priority order 1,0,2; each slave drops req once acked.
    n_ack = 0;
    gq.delete();
    rq = 3'b111;
    repeat (40) begin
      cycle(rq, pv(2, 1, 3), lv(1, 1, 1), 7'd64);
      rq = rq & ~last_ack;
    end
    chk("t2_ngnt", 64'(gq.size()), 64'd3);
    chk("t2_acks", 64'(n_ack), 64'd24);
    if (gq.size() == 3) begin
      chk("t2_g0", 64'(gq[0]), 64'd1);
      chk("t2_g1", 64'(gq[1]), 64'd0);
      chk("t2_g2", 64'(gq[2]), 64'd2);
    end

    // Equal prio, all held: rotation continues from ch2.
    gq.delete();
    repeat (30) cycle(3'b111, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
    repeat (8) cycle(3'b000, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
    chk("t3_ngnt_ge4", 64'(gq.size() >= 4), 64'd1);
    if (gq.size() >= 4) begin
      chk("t3_g0", 64'(gq[0]), 64'd0);
      chk("t3_g1", 64'(gq[1]), 64'd1);
      chk("t3_g2", 64'(gq[2]), 64'd2);
      chk("t3_g3", 64'(gq[3]), 64'd0);
    end

    // 32-word packet blocked by margin 20, released at 32.
    n_ack = 0;
    repeat (10) cycle(3'b100, pv(0, 0, 0), lv(0, 0, 3), 7'd20);
    chk("t4_blocked", 64'(n_ack), 64'd0);
    cycle(3'b100, pv(0, 0, 0), lv(0, 0, 3), 7'd32);
    repeat (40) cycle(3'b000, pv(0, 0, 0), lv(0, 0, 3), 7'd32);
    chk("t4_acks", 64'(n_ack), 64'd32);

    // pkglen changes 0->2 during GRANT: length stays latched at 4.
    n_ack = 0;
    cycle(3'b001, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
    repeat (10) cycle(3'b000, pv(3, 0, 0), lv(2, 0, 0), 7'd64);
    chk("t5_acks", 64'(n_ack), 64'd4);

    // Reset in the middle of a GRANT.
    cycle(3'b010, pv(0, 0, 0), lv(0, 1, 0), 7'd64);
    repeat (3) cycle(3'b000, pv(0, 0, 0), lv(0, 1, 0), 7'd64);
    chk("t6_pre_ack", 64'(ack), 64'b010);
    rstn = 1'b0;
    #1;
    chk("t6_ack",   64'(ack),   64'd0);
    chk("t6_valid", 64'(av),    64'd0);
    chk("t6_busy",  64'(abusy), 64'd0);
    do_reset();

    // Random traffic against the model.
    repeat (600) begin
      cycle(N'($urandom), N*2'($urandom), N*3'($urandom),
            ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 64)) : 7'd64);
    end
    repeat (40) cycle(3'b000, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
`ifdef ARB_STAT_EN
    for (int k = 0; k < N; k++)
      chk("stat_rand", 64'(stat[k*16 +: 16]), 64'(mstat[k]));
`endif

    // Three packets on ch1 after a clean reset.
    do_reset();
    repeat (3) begin
      cycle(3'b010, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
      repeat (8) cycle(3'b000, pv(0, 0, 0), lv(0, 0, 0), 7'd64);
    end
`ifdef ARB_STAT_EN
    chk("stat_ch0", 64'(stat[15:0]),  64'd0);
    chk("stat_ch1", 64'(stat[31:16]), 64'd3);
    chk("stat_ch2", 64'(stat[47:32]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
